// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer scan-out block.
// Holds the frame-buffer geometry, the 640x480@60 VGA timing constants,
// the RGB444 pixel type, the per-pixel control bundle carried down the
// read pipeline, the scan-out FSM state type and the address helper.
package fb_pkg;

    localparam int unsigned FB_W      = 320;
    localparam int unsigned FB_H      = 240;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned PIX_W     = 12;

    // Horizontal timing, in pixels
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Width of the h/v counters (both totals fit in 10 bits)
    localparam int unsigned CNT_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Sync/active state of one pixel, delayed alongside the memory read
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic active;
    } pix_ctl_t;

    localparam pix_ctl_t CTL_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_t;

    // y*320 + x built from shifts: y*256 + y*64 + x
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] x,
                                                     input logic [7:0] y);
        logic [FB_ADDR_W-1:0] yy;
        logic [FB_ADDR_W-1:0] xx;
        yy = {{(FB_ADDR_W-8){1'b0}}, y};
        xx = {{(FB_ADDR_W-9){1'b0}}, x};
        return (yy << 8) + (yy << 6) + xx;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA 640x480 timing generator.
// A free-running divider produces one pixel tick every CLK_DIV clocks;
// the h (0..799) and v (0..524) counters advance only on a tick while
// run is high and are held at zero otherwise.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               counters enabled (scan-out FSM in RUN)
//   tick              pixel tick, one clock wide
//   fb_x, fb_y        2x-downscaled frame-buffer coordinates (h>>1, v>>1)
//   hsync_n, vsync_n  raw active-low sync decode of the current h/v
//   active            current h/v lies in the visible 640x480 area
//   vblank            v is in the vertical blanking interval (v >= 480)
//   line_end          h is the last pixel of a line (799)
//   frame_end         v is the last line of a frame (524)
//   last_active_line  v is the last visible line (479)
module vga_timing_gen
    import fb_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       tick,
    output logic [8:0] fb_x,
    output logic [7:0] fb_y,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active,
    output logic       vblank,
    output logic       line_end,
    output logic       frame_end,
    output logic       last_active_line
);

    localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [3:0]       div;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    assign line_end         = (h == H_LAST);
    assign frame_end        = (v == V_LAST);
    assign last_active_line = (v == V_ACT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (!run) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (line_end) begin
                h <= '0;
                v <= frame_end ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign fb_x    = h[9:1];
    assign fb_y    = v[8:1];
    assign hsync_n = !((h >= HS_BEGIN) && (h < HS_END));
    assign vsync_n = !((v >= VS_BEGIN) && (v < VS_END));
    assign active  = (h < H_ACT) && (v < V_ACT);
    assign vblank  = (v >= V_ACT);

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: reads a 320x240 RGB444 frame buffer and drives
// a 640x480 VGA stream, each source pixel doubled in both directions.
// Ports:
//   i_clk, i_rst_n         system clock, asynchronous active-low reset
//   i_enable               request to scan out frames
//   o_fb_r_addr, o_fb_r_en frame-buffer read address (y*320+x) and strobe
//   i_fb_r_data            RGB444 read data, valid one clock after o_fb_r_en
//   o_vga_r/g/b            colour outputs (zero outside the active area)
//   o_hsync, o_vsync       active-low syncs, aligned with the colour
//   o_vblank               vertical blanking (also high while idle)
//   o_frame_done           one-clock pulse at the end of the last active line
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    output logic [FB_ADDR_W-1:0] o_fb_r_addr,
    output logic                 o_fb_r_en,
    input  logic [PIX_W-1:0]     i_fb_r_data,
    output logic [3:0]           o_vga_r,
    output logic [3:0]           o_vga_g,
    output logic [3:0]           o_vga_b,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_vblank,
    output logic                 o_frame_done
);

    scan_state_t state;
    scan_state_t state_nx;

    logic       run;
    logic       tick;
    logic [8:0] fb_x;
    logic [7:0] fb_y;
    logic       hsync_n;
    logic       vsync_n;
    logic       active;
    logic       vblank;
    logic       line_end;
    logic       frame_end;
    logic       last_active_line;
    logic       pix_act;

    pix_ctl_t   s1;
    pix_ctl_t   s2;
    logic       t1;
    logic       t2;
    rgb444_t    rgb;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tg (
        .clk              (i_clk),
        .rst_n            (i_rst_n),
        .run              (run),
        .tick             (tick),
        .fb_x             (fb_x),
        .fb_y             (fb_y),
        .hsync_n          (hsync_n),
        .vsync_n          (vsync_n),
        .active           (active),
        .vblank           (vblank),
        .line_end         (line_end),
        .frame_end        (frame_end),
        .last_active_line (last_active_line)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Leaving RUN only at the final tick of a frame lets a mid-frame
    // disable finish the frame in progress.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (tick && i_enable) state_nx = ST_RUN;
            ST_RUN:  if (tick && line_end && frame_end && !i_enable) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign run     = (state == ST_RUN);
    assign pix_act = run && active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fb_r_en    <= 1'b0;
            o_fb_r_addr  <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_fb_r_en    <= tick && pix_act;
            o_frame_done <= tick && run && line_end && last_active_line;
            if (tick && pix_act) begin
                o_fb_r_addr <= fb_addr(fb_x, fb_y);
            end
        end
    end

    // Sync/active for the ticked pixel travel two stages so they reach the
    // outputs on the same edge that captures that pixel's read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1      <= CTL_IDLE;
            s2      <= CTL_IDLE;
            t1      <= 1'b0;
            t2      <= 1'b0;
            rgb     <= '0;
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
        end else begin
            t1 <= tick;
            t2 <= t1;
            if (tick) begin
                s1 <= '{hsync_n: hsync_n || !run,
                        vsync_n: vsync_n || !run,
                        active:  pix_act};
            end
            if (t1) begin
                s2 <= s1;
            end
            if (t2) begin
                o_hsync <= s2.hsync_n;
                o_vsync <= s2.vsync_n;
                rgb     <= s2.active ? rgb444_t'(i_fb_r_data) : '0;
            end
        end
    end

    assign o_vga_r  = rgb.r;
    assign o_vga_g  = rgb.g;
    assign o_vga_b  = rgb.b;
    assign o_vblank = !run || vblank;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout with CLK_DIV=4 (one line = 3200 clocks).
// Frame buffer model returns addr[11:0] one clock after each read strobe.
// Whole frames are too long to simulate, so the vertical counter inside
// the timing generator is moved forward at a few mid-line points; the
// frame_done spacing check subtracts exactly the lines skipped that way.
// Times below are clock counts relative to the edge of the (0,0) tick,
// i.e. the first negedge at which the read strobe is seen.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [16:0] addr;
    logic        rd;
    logic [11:0] data = '0;
    logic [3:0]  r, g, b;
    logic        hs, vs, vb, fd;
    logic [11:0] rgb;

    int          tests = 0;
    int          fails = 0;
    longint      cyc = 0;
    longint      base = 0;
    longint      rel_start;
    longint      skip = 0;
    int          fd_cnt = 0;
    longint      fd_t1 = 0, fd_t2 = 0;
    int          bad;
    int          wait_n;

    assign rgb = {r, g, b};

    fb_scanout #(.CLK_DIV(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .o_fb_r_addr  (addr),
        .o_fb_r_en    (rd),
        .i_fb_r_data  (data),
        .o_vga_r      (r),
        .o_vga_g      (g),
        .o_vga_b      (b),
        .o_hsync      (hs),
        .o_vsync      (vs),
        .o_vblank     (vb),
        .o_frame_done (fd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd) data <= addr[11:0];
    end

    always @(negedge clk) begin
        if (fd) begin
            fd_cnt = fd_cnt + 1;
            if (fd_cnt == 1) fd_t1 = cyc;
            else if (fd_cnt == 2) fd_t2 = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic at(input longint t);
        while (cyc < base + t) @(negedge clk);
    endtask

    task automatic wait_first_read(output longint edge_no);
        wait_n = 0;
        while (!rd && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("first_read_seen", 32'(rd), 32'd1);
        edge_no = cyc;
    endtask

    task automatic jump_v(input logic [9:0] to);
        force dut.u_tg.v = to;
        @(negedge clk);
        release dut.u_tg.v;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_hsync", 32'(hs), 32'd1);
        check("rst_vsync", 32'(vs), 32'd1);
        check("rst_vblank", 32'(vb), 32'd1);
        check("rst_frame_done", 32'(fd), 32'd0);

        // Release with enable: tick 1 enters RUN, tick 2 is pixel (0,0)
        enable = 1'b1;
        rst_n = 1'b1;
        rel_start = cyc;
        wait_first_read(base);
        check("first_read_latency", 32'(base - rel_start), 32'd8);
        check("addr_0_0", 32'(addr), 32'd0);
        check("vblank_run_active", 32'(vb), 32'd0);

        at(2);    check("rgb_0_0", 32'(rgb), 32'h000);
        at(4);    check("addr_1_0", 32'(addr), 32'd0);
        at(6);    check("rgb_1_0", 32'(rgb), 32'h000);
        at(8);    check("rd_2_0", 32'(rd), 32'd1);
                  check("addr_2_0", 32'(addr), 32'd1);
        at(10);   check("rgb_2_0", 32'(rgb), 32'h001);
        at(2556); check("addr_639_0", 32'(addr), 32'd319);
        at(2558); check("rgb_639_0", 32'(rgb), 32'h13F);
        at(2560); check("rd_640_0", 32'(rd), 32'd0);

        // Horizontal blanking of line 0, with the hsync pulse edges
        bad = 0;
        for (longint t = 2562; t < 3200; t++) begin
            at(t);
            if (rd || rgb != 12'h000) bad++;
            if (t == 2625) check("hsync_before_fall", 32'(hs), 32'd1);
            if (t == 2626) check("hsync_fall", 32'(hs), 32'd0);
            if (t == 3009) check("hsync_still_low", 32'(hs), 32'd0);
            if (t == 3010) check("hsync_rise", 32'(hs), 32'd1);
        end
        check("hblank_reads_or_rgb", 32'(bad), 32'd0);

        at(3200); check("addr_0_1", 32'(addr), 32'd0);
        at(3202); check("rgb_0_1", 32'(rgb), 32'h000);
        at(3206); check("rgb_1_1", 32'(rgb), 32'h000);
        at(5825); check("hsync_line1_before", 32'(hs), 32'd1);
        at(5826); check("hsync_line1_fall", 32'(hs), 32'd0);
        at(6400); check("rd_0_2", 32'(rd), 32'd1);
                  check("addr_0_2", 32'(addr), 32'd320);
        at(6402); check("rgb_0_2", 32'(rgb), 32'h140);

        // Frame 1: jump from line 2 to line 478
        at(6500); jump_v(10'd478);
        at(9600);  check("addr_0_479", 32'(addr), 32'd76480);
        at(12156); check("rd_last_pixel", 32'(rd), 32'd1);
                   check("addr_last_pixel", 32'(addr), 32'd76799);
        at(12158); check("rgb_last_pixel", 32'(rgb), 32'hBFF);
        at(12795); check("vblank_before_480", 32'(vb), 32'd0);
                   check("frame_done_early", 32'(fd), 32'd0);
        at(12796); check("vblank_at_480", 32'(vb), 32'd1);
                   check("frame_done_pulse1", 32'(fd), 32'd1);
        at(12797); check("frame_done_one_clock", 32'(fd), 32'd0);

        // Vertical blanking: line 480 in full, then 489..492 for vsync
        bad = 0;
        for (longint t = 12797; t < 16100; t++) begin
            at(t);
            if (rd || rgb != 12'h000) bad++;
        end
        jump_v(10'd489); skip += 8;
        for (longint t = 16101; t < 25700; t++) begin
            at(t);
            if (rd || rgb != 12'h000) bad++;
            if (t == 19201) check("vsync_before_fall", 32'(vs), 32'd1);
            if (t == 19202) check("vsync_fall", 32'(vs), 32'd0);
            if (t == 25601) check("vsync_still_low", 32'(vs), 32'd0);
            if (t == 25602) check("vsync_rise", 32'(vs), 32'd1);
        end
        jump_v(10'd523); skip += 31;
        for (longint t = 25701; t < 32000; t++) begin
            at(t);
            if (rd || rgb != 12'h000) bad++;
        end
        check("vblank_reads_or_rgb", 32'(bad), 32'd0);

        // h=799,v=524 wraps both counters on one tick
        at(32000); check("wrap_rd", 32'(rd), 32'd1);
                   check("wrap_addr", 32'(addr), 32'd0);
                   check("wrap_vblank", 32'(vb), 32'd0);

        // Frame 2: drop enable on line 100; the frame must still complete
        at(32100); jump_v(10'd99); skip += 99;
        at(35300); enable = 1'b0;
        at(35400); jump_v(10'd478); skip += 378;
        at(35600); check("rd_after_disable", 32'(rd), 32'd1);
                   check("addr_after_disable", 32'(addr), 32'd76530);
        at(41596); check("frame_done_pulse2", 32'(fd), 32'd1);
        at(41600); check("frame_done_count", 32'(fd_cnt), 32'd2);
                   check("frame_done_spacing", 32'(fd_t2 - fd_t1),
                         32'(64'd1680000 - skip * 64'd3200));
        at(41700); jump_v(10'd523);

        // End of frame 2 with enable low: IDLE, no reads, syncs high
        at(48000); check("idle_no_read_0_0", 32'(rd), 32'd0);
        bad = 0;
        for (longint t = 47997; t < 48800; t++) begin
            at(t);
            if (rd || !hs || !vs || !vb || rgb != 12'h000) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        check("frame_done_count_idle", 32'(fd_cnt), 32'd2);

        // Re-enable, then reset asynchronously in the middle of line 0
        enable = 1'b1;
        wait_first_read(base);
        check("reenable_addr", 32'(addr), 32'd0);
        at(400);   check("pre_reset_rd", 32'(rd), 32'd1);
                   check("pre_reset_addr", 32'(addr), 32'd50);
                   check("pre_reset_rgb", 32'(rgb), 32'h031);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", 32'(rgb), 32'd0);
        check("async_rst_hsync", 32'(hs), 32'd1);
        check("async_rst_vsync", 32'(vs), 32'd1);
        check("async_rst_rd", 32'(rd), 32'd0);
        check("async_rst_addr", 32'(addr), 32'd0);
        check("async_rst_vblank", 32'(vb), 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        rel_start = cyc;
        wait_first_read(base);
        check("restart_latency", 32'(base - rel_start), 32'd8);
        check("restart_addr", 32'(addr), 32'd0);
        at(2); check("restart_rgb_0_0", 32'(rgb), 32'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
